conv_encoder_k3: RTL and testbench

Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder path, and it produces exactly the 2-bit symbol stream the branch-metric and ACS stages consume. Input bits arrive on a valid/ready stream and encoded symbols leave on a registered valid/ready stream. Each frame is terminated with K-1 zero tail bits, so the trellis ends in state 00, matching the decoder's start state (metric 0 for 00, INF elsewhere).

---
 rtl/viterbi_pkg.sv | 27 ++
 rtl/conv_encoder_k3.sv | 111 +++++++++++
 tb/tb_conv_encoder_k3.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants, state encoding and parity helper for the K=3 rate-1/2
// convolutional encoder and the Viterbi decoder path that consumes its symbols.
package viterbi_pkg;

    localparam int K       = 3;
    localparam int STATE_W = 2;

    // Octal 7 and octal 5: the classic K=3 code pair.
    localparam logic [K-1:0] G0_DEF = 3'b111;
    localparam logic [K-1:0] G1_DEF = 3'b101;

    // Encoder FSM states; the shift register value itself is the trellis
    // state (00/01/10/11) and is shared with the decoder's naming.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } enc_state_e;

    // Parity of generator g applied to {current bit, b(n-1), b(n-2)}.
    function automatic logic conv_parity(input logic [K-1:0]       g,
                                         input logic               b,
                                         input logic [STATE_W-1:0] sr);
        return ^(g & {b, sr});
    endfunction

endpackage

// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder with valid/ready on both sides.
// Each accepted bit yields one registered 2-bit symbol; frames are optionally
// flushed with two zero tail bits so the trellis ends in state 00.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; a producer holding valid keeps its payload stable until that edge, and
// ready never depends combinationally on the same side's valid.
module conv_encoder_k3
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] G0      = G0_DEF,
    parameter logic [K-1:0] G1      = G1_DEF,
    parameter bit           TAIL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_sym,
    output logic       out_last,
    output logic       busy
);

    enc_state_e         state_q, state_d;
    logic [STATE_W-1:0] sr_q, sr_d;
    logic [1:0]         tail_cnt_q, tail_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [1:0]         out_sym_q, out_sym_d;
    logic               out_last_q, out_last_d;

    logic slot_free;
    logic accept;

    // The output register can take a new symbol when empty or being drained.
    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q != ST_TAIL) && slot_free;
    assign accept    = in_valid && in_ready;

    // Next-state: load a data symbol, a tail symbol, or hold under backpressure.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        tail_cnt_d  = tail_cnt_q;
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_last_d  = out_last_q;

        if (slot_free) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (accept) begin
            out_valid_d = 1'b1;
            out_sym_d   = {conv_parity(G0, in_bit, sr_q), conv_parity(G1, in_bit, sr_q)};
            out_last_d  = 1'b0;
            sr_d        = {in_bit, sr_q[1]};
            state_d     = ST_DATA;
            if (in_last) begin
                if (TAIL_EN) begin
                    state_d    = ST_TAIL;
                    tail_cnt_d = 2'd2;
                end else begin
                    // No flush: mark this symbol as the end and restart from 00.
                    state_d    = ST_IDLE;
                    sr_d       = '0;
                    out_last_d = 1'b1;
                end
            end
        end else if (state_q == ST_TAIL && slot_free) begin
            out_valid_d = 1'b1;
            out_sym_d   = {conv_parity(G0, 1'b0, sr_q), conv_parity(G1, 1'b0, sr_q)};
            sr_d        = {1'b0, sr_q[1]};
            tail_cnt_d  = tail_cnt_q - 2'd1;
            if (tail_cnt_q == 2'd1) begin
                out_last_d = 1'b1;
                state_d    = ST_IDLE;
                sr_d       = '0;
            end
        end
    end

    // All state, including the registered output symbol, with async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            tail_cnt_q  <= 2'd0;
            out_valid_q <= 1'b0;
            out_sym_q   <= 2'b00;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            tail_cnt_q  <= tail_cnt_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sym   = out_sym_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != ST_IDLE) || out_valid_q;

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Bench for conv_encoder_k3: one instance with tail flush, one without.
module tb_conv_encoder_k3;
    import viterbi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic       in_ready, out_valid, out_last, busy;
    logic [1:0] out_sym;

    logic       in0_valid = 1'b0, in0_bit = 1'b0, in0_last = 1'b0, out0_ready = 1'b1;
    logic       in0_ready, out0_valid, out0_last, busy0;
    logic [1:0] out0_sym;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];
    logic [2:0] exp0_q[$];

    typedef struct {
        logic       drive;
        logic       in_bit;
        logic       in_last;
        logic [1:0] exp_sym;
        logic       exp_last;
        int         exp_wait;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    conv_encoder_k3 dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym), .out_last(out_last),
        .busy(busy)
    );

    conv_encoder_k3 #(.TAIL_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in0_valid), .in_ready(in0_ready), .in_bit(in0_bit), .in_last(in0_last),
        .out_valid(out0_valid), .out_ready(out0_ready), .out_sym(out0_sym), .out_last(out0_last),
        .busy(busy0)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Reference encoder for the 7/5 code, written as explicit tap equations.
    function automatic logic [1:0] ref_sym(input logic b, input logic [1:0] s);
        return {b ^ s[1] ^ s[0], b ^ s[0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: present a bit and hold it until accepted; counts stall cycles.
    task automatic send_bit(input int which, input logic b, input logic last, input int exp_wait);
        int   waits = 0;
        logic acc = 1'b0;
        if (which == 0) begin
            in_valid = 1'b1; in_bit = b; in_last = last;
        end else begin
            in0_valid = 1'b1; in0_bit = b; in0_last = last;
        end
        while (!acc && waits < 100) begin
            @(negedge clk);
            acc = (which == 0) ? in_ready : in0_ready;
            if (!acc) waits++;
            @(posedge clk);
            #1;
        end
        chk("accept_timeout", {31'd0, acc}, 32'd1);
        if (exp_wait >= 0) chk("stall_cycles", waits, exp_wait);
    endtask

    task automatic wait_idle(input int which);
        logic done = 1'b0;
        if (which == 0) in_valid = 1'b0; else in0_valid = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (which == 0) done = (exp_q.size() == 0) && !busy;
            else            done = (exp0_q.size() == 0) && !busy0;
        end
        chk("drain_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic push_exp(input logic [1:0] s, input logic l);
        exp_q.push_back({s, l});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] msr;
        logic [1:0] hold_sym;
        logic       hold_last;
        logic       stop;
        int         n;
        logic       b;

        // Table: frame 1011, single-bit frame, two back-to-back 1011 frames.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 2};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 2};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 2};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 0};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 0};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 0};

        // Scoreboard monitors: pop and compare on every output transfer.
        fork
            forever begin
                logic [2:0] e;
                @(negedge clk);
                if (rst_n && out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("sym_unexpected", {29'd0, out_sym, out_last}, 32'h1ff);
                    else begin
                        e = exp_q.pop_front();
                        chk("sym", {29'd0, out_sym, out_last}, {29'd0, e});
                    end
                end
                if (rst_n && out0_valid && out0_ready) begin
                    if (exp0_q.size() == 0) chk("sym0_unexpected", {29'd0, out0_sym, out0_last}, 32'h1ff);
                    else begin
                        e = exp0_q.pop_front();
                        chk("sym0", {29'd0, out0_sym, out0_last}, {29'd0, e});
                    end
                end
            end
        join_none

        // Reset values
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sym", {30'd0, out_sym}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Table-driven frames with out_ready held high.
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].drive) begin
                push_exp(vecs[i].exp_sym, vecs[i].exp_last);
                for (int j = i + 1; j < NV && !vecs[j].drive; j++)
                    push_exp(vecs[j].exp_sym, vecs[j].exp_last);
                send_bit(0, vecs[i].in_bit, vecs[i].in_last, vecs[i].exp_wait);
            end
        end
        wait_idle(0);
        chk("idle_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
        chk("idle_sr", {30'd0, dut.sr_q}, 32'd0);
        @(posedge clk); #1;

        // Backpressure: 3 stalled cycles in the middle of frame 1011.
        push_exp(2'b11, 1'b0); push_exp(2'b10, 1'b0); push_exp(2'b00, 1'b0);
        push_exp(2'b01, 1'b0); push_exp(2'b01, 1'b0); push_exp(2'b11, 1'b1);
        fork
            begin
                send_bit(0, 1'b1, 1'b0, 0);
                send_bit(0, 1'b0, 1'b0, 0);
                send_bit(0, 1'b1, 1'b0, -1);
                send_bit(0, 1'b1, 1'b1, -1);
                wait_idle(0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (k == 0) begin
                        hold_sym  = out_sym;
                        hold_last = out_last;
                    end else begin
                        chk("bp_sym_held", {30'd0, out_sym}, {30'd0, hold_sym});
                        chk("bp_last_held", {31'd0, out_last}, {31'd0, hold_last});
                    end
                    chk("bp_valid", {31'd0, out_valid}, 32'd1);
                    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        @(posedge clk); #1;

        // TAIL_EN=0: frame 1,0(last) then a fresh frame 1(last).
        exp0_q.push_back({2'b11, 1'b0});
        exp0_q.push_back({2'b10, 1'b1});
        exp0_q.push_back({2'b11, 1'b1});
        send_bit(1, 1'b1, 1'b0, 0);
        send_bit(1, 1'b0, 1'b1, 0);
        send_bit(1, 1'b1, 1'b1, 0);
        wait_idle(1);
        @(posedge clk); #1;

        // Random frames against the reference model, second one with random backpressure.
        for (int f = 0; f < 2; f++) begin
            msr = 2'b00;
            n = $urandom_range(3, 8);
            stop = 1'b0;
            fork
                begin
                    for (int i = 0; i < n; i++) begin
                        b = 1'($urandom_range(0, 1));
                        push_exp(ref_sym(b, msr), 1'b0);
                        msr = {b, msr[1]};
                        if (i == n - 1) begin
                            push_exp(ref_sym(1'b0, msr), 1'b0);
                            msr = {1'b0, msr[1]};
                            push_exp(ref_sym(1'b0, msr), 1'b1);
                        end
                        send_bit(0, b, (i == n - 1), (f == 0) ? 0 : -1);
                    end
                    wait_idle(0);
                    stop = 1'b1;
                end
                begin
                    while (f == 1 && !stop) begin
                        @(posedge clk);
                        #1 out_ready = 1'($urandom_range(0, 1));
                    end
                    out_ready = 1'b1;
                end
            join
            out_ready = 1'b1;
            @(posedge clk); #1;
        end

        // Reset mid-frame with a symbol pending.
        push_exp(2'b11, 1'b0); push_exp(2'b10, 1'b0);
        send_bit(0, 1'b1, 1'b0, 0);
        send_bit(0, 1'b0, 1'b0, 0);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_sr", {30'd0, dut.sr_q}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        push_exp(2'b11, 1'b0); push_exp(2'b10, 1'b0); push_exp(2'b11, 1'b1);
        send_bit(0, 1'b1, 1'b1, 0);
        wait_idle(0);
        chk("post_rst_queue_empty", exp_q.size(), 32'd0);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
